// File: rtl/conv2_out_stage_if.sv
// rtl/conv2_out_stage_if.sv - result stream interface for conv2_out_stage
//  Carries the requantized FIFO head toward pooling / feature-map storage.
//  out_data  : signed requantized result (FIFO head)
//  out_last  : head is the final result of a frame
//  out_valid : FIFO non-empty
//  out_ready : downstream accepts head when out_valid & out_ready
//  master = producer (conv2_out_stage), slave = consumer.
interface conv2_out_stage_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/conv2_out_stage.sv
// rtl/conv2_out_stage.sv - conv2 PE accumulator requantize + output FIFO
//  Captures completed PE sums on acc_last_i, rounds/shifts/ReLUs/saturates to int8,
//  tags frame ends and buffers results in a DEPTH-entry FIFO feeding a valid/ready stream.
//  clk        : clock
//  rst_n      : asynchronous reset, active-low
//  clr_i      : synchronous flush of pipeline, FIFO, frame counter and ovf_o
//  acc_i      : signed PE accumulator value
//  acc_last_i : 1-cycle strobe, acc_i holds a completed sum
//  out_if     : result stream (out_data/out_last/out_valid/out_ready)
//  ovf_o      : sticky, a result was dropped on a full FIFO
//  level_o    : current FIFO occupancy (0..DEPTH)
module conv2_out_stage #(
  parameter int ACC_W     = 20,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 6,
  parameter int RELU      = 1,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic                     acc_last_i,
  conv2_out_stage_if.master        out_if,
  output logic                     ovf_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0]      FC_LAST = FC_W'(FRAME_LEN - 1);
  // Half-LSB rounding constant; zero when no shift is applied.
  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic [AW:0]           LVL_FULL = (AW+1)'(DEPTH);

  // ---------------- stage 1: round and shift ----------------
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_shr;
  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic signed [ACC_W:0] r_s1_val;
  logic [FC_W-1:0]       r_frame_cnt;

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  assign w_sum = $signed({acc_i[ACC_W-1], acc_i}) + RND;
  assign w_shr = w_sum >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_val    <= '0;
      r_frame_cnt <= '0;
    end else if (clr_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_val    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_s1_valid <= acc_last_i;
      if (acc_last_i) begin
        r_s1_val  <= w_shr;
        r_s1_last <= (r_frame_cnt == FC_LAST);
        // Counts every strobe, even ones later dropped, to keep frame alignment.
        r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
      end
    end
  end

  // ---------------- stage 2: ReLU and saturate ----------------
  logic signed [ACC_W:0] w_relu;
  logic [OUT_W-1:0]      w_sat;

  always_comb begin
    w_relu = r_s1_val;
    if ((RELU != 0) && r_s1_val[ACC_W]) begin
      w_relu = '0;
    end
    w_sat = w_relu[OUT_W-1:0];
    if (w_relu > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_relu < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  // ---------------- output FIFO ----------------
  logic [OUT_W:0]  r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_level;
  logic            r_ovf;
  logic            w_full;
  logic            w_nonempty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [OUT_W:0]  w_head;

  assign w_full     = (r_level == LVL_FULL);
  assign w_nonempty = (r_level != '0);
  assign w_pop      = w_nonempty & out_if.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = r_s1_valid & (~w_full | w_pop);
  assign w_drop     = r_s1_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push && !clr_i) begin
      r_mem[r_wptr] <= {r_s1_last, w_sat};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign w_head           = r_mem[r_rptr];
  assign out_if.out_valid = w_nonempty;
  assign out_if.out_data  = w_nonempty ? w_head[OUT_W-1:0] : '0;
  assign out_if.out_last  = w_nonempty ? w_head[OUT_W] : 1'b0;
  assign ovf_o            = r_ovf;
  assign level_o          = r_level;

endmodule
